posit_operand_sequencer: RTL and testbench

POSIT_OPERAND_SEQUENCER -- requirements
Module: posit_operand_sequencer

---
 rtl/posit_seq_pkg.sv | 28 ++
 rtl/Data_Extraction.sv | 64 ++++++
 rtl/posit_operand_sequencer.sv | 119 +++++++++++
 tb/tb_posit_operand_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_seq_pkg.sv
// Shared types for the posit operand sequencer.
//   N, ES, RS  : posit word, exponent field and regime magnitude widths
//   decoded_t  : one decoded posit operand
//   state_t    : sequencer FSM states
package posit_seq_pkg;

    localparam int unsigned N  = 8;
    localparam int unsigned ES = 4;
    localparam int unsigned RS = $clog2(N);

    // Mantissa carries the hidden bit in its MSB, fraction left-aligned below it.
    typedef struct packed {
        logic                sign;
        logic signed [RS:0]  regime;
        logic [ES-1:0]       exponent;
        logic [N-1:0]        mantissa;
        logic                inf;
        logic                zero;
    } decoded_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEC_A = 2'd1,
        DEC_B = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/Data_Extraction.sv
// Combinational posit field extractor.
//   i_word  : raw posit word
//   o_dec_c : decoded fields {sign, regime, exponent, mantissa, inf, zero}
// Widths of o_dec_c come from posit_seq_pkg; N/ES/RS must match the package.
module Data_Extraction
    import posit_seq_pkg::decoded_t;
#(
    parameter int unsigned N  = posit_seq_pkg::N,
    parameter int unsigned ES = posit_seq_pkg::ES,
    parameter int unsigned RS = posit_seq_pkg::RS
) (
    input  logic [N-1:0] i_word,
    output decoded_t     o_dec_c
);

    localparam int unsigned BW = N - 1;   // body width below the sign bit
    localparam int unsigned FW = BW - ES; // fraction bits available after exponent

    logic [BW-1:0] w_body;
    logic [BW-1:0] w_shift;
    logic [RS:0]   w_run;
    logic          w_rc;
    logic          w_stop;
    logic          w_is_zero;
    logic          w_is_nar;

    // Negative posits are decoded from their two's complement magnitude.
    always_comb begin
        w_is_zero = (i_word == '0);
        w_is_nar  = (i_word == {1'b1, {BW{1'b0}}});
        w_body    = i_word[N-1] ? (~i_word[BW-1:0] + BW'(1)) : i_word[BW-1:0];
        w_rc      = w_body[BW-1];

        // Length of the leading run of regime bits.
        w_run  = '0;
        w_stop = 1'b0;
        for (int i = int'(BW) - 1; i >= 0; i--) begin
            if (!w_stop) begin
                if (w_body[i] == w_rc) begin
                    w_run = w_run + (RS+1)'(1);
                end else begin
                    w_stop = 1'b1;
                end
            end
        end

        // Drop regime run and its terminator; exponent then fraction remain.
        w_shift = w_body << (w_run + (RS+1)'(1));

        o_dec_c = '0;
        if (w_is_nar) begin
            o_dec_c.sign = 1'b1;
            o_dec_c.inf  = 1'b1;
        end else if (w_is_zero) begin
            o_dec_c.zero = 1'b1;
        end else begin
            o_dec_c.sign     = i_word[N-1];
            o_dec_c.regime   = w_rc ? (w_run - (RS+1)'(1)) : ((RS+1)'(0) - w_run);
            o_dec_c.exponent = w_shift[BW-1 -: ES];
            o_dec_c.mantissa = {1'b1, w_shift[FW-1:0], {ES{1'b0}}};
        end
    end

endmodule

// File: rtl/posit_operand_sequencer.sv
// Decodes a posit operand pair through one time-shared extractor.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand pair handshake, in_a/in_b raw posits
//   out_valid/out_ready : decoded pair handshake, out_a/out_b decoded operands
//   out_nar             : either decoded operand is NaR
//   pair_count          : completed output handshakes (wrapping)
//   busy                : sequencer not idle
module posit_operand_sequencer
    import posit_seq_pkg::decoded_t, posit_seq_pkg::state_t;
    import posit_seq_pkg::IDLE, posit_seq_pkg::DEC_A, posit_seq_pkg::DEC_B, posit_seq_pkg::HOLD;
#(
    parameter int unsigned N  = posit_seq_pkg::N,
    parameter int unsigned ES = posit_seq_pkg::ES,
    parameter int unsigned RS = posit_seq_pkg::RS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output decoded_t     out_a,
    output decoded_t     out_b,
    output logic         out_nar,
    output logic [15:0]  pair_count,
    output logic         busy
);

    state_t      r_state;
    logic [N-1:0] r_a_q;
    logic [N-1:0] r_b_q;
    decoded_t    r_out_a;
    decoded_t    r_out_b;
    logic [15:0] r_pair_count;

    logic [N-1:0] w_ext_in;
    decoded_t     w_dec;
    logic         w_accept;
    logic         w_out_fire;

    // Extractor sees a_q in DEC_A, b_q in DEC_B and zero otherwise.
    always_comb begin
        w_ext_in = '0;
        case (r_state)
            DEC_A:   w_ext_in = r_a_q;
            DEC_B:   w_ext_in = r_b_q;
            default: w_ext_in = '0;
        endcase
    end

    Data_Extraction #(
        .N  (N),
        .ES (ES),
        .RS (RS)
    ) u_extract (
        .i_word  (w_ext_in),
        .o_dec_c (w_dec)
    );

    assign in_ready   = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
    assign out_valid  = (r_state == HOLD);
    assign busy       = (r_state != IDLE);
    assign out_a      = r_out_a;
    assign out_b      = r_out_b;
    assign out_nar    = r_out_a.inf | r_out_b.inf;
    assign pair_count = r_pair_count;

    assign w_accept   = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // Sequencer FSM with operand and result register banks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_a_q        <= '0;
            r_b_q        <= '0;
            r_out_a      <= '0;
            r_out_b      <= '0;
            r_pair_count <= '0;
        end else begin
            if (w_out_fire) begin
                r_pair_count <= r_pair_count + 16'd1;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a_q   <= in_a;
                        r_b_q   <= in_b;
                        r_state <= DEC_A;
                    end
                end
                DEC_A: begin
                    r_out_a <= w_dec;
                    r_state <= DEC_B;
                end
                DEC_B: begin
                    r_out_b <= w_dec;
                    r_state <= HOLD;
                end
                HOLD: begin
                    // A new pair may be taken in the same cycle the result leaves.
                    if (out_ready) begin
                        if (in_valid) begin
                            r_a_q   <= in_a;
                            r_b_q   <= in_b;
                            r_state <= DEC_A;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_operand_sequencer.sv
// Self-checking bench for posit_operand_sequencer against a posit decoding model.
module tb_posit_operand_sequencer;
    import posit_seq_pkg::*;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    decoded_t     out_a;
    decoded_t     out_b;
    logic         out_nar;
    logic [15:0]  pair_count;
    logic         busy;

    int          errors;
    int          checks;
    logic [15:0] exp_count;

    posit_operand_sequencer #(.N(N), .ES(ES), .RS(RS)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_nar    (out_nar),
        .pair_count (pair_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posit decode from the number-format definition: magnitude, regime run, exponent, fraction.
    function automatic decoded_t ref_decode(input logic [N-1:0] x);
        decoded_t d;
        int v, first, m, k, rem, remval, fb;
        d = '0;
        if (int'(x) == 0) begin
            d.zero = 1'b1;
            return d;
        end
        if (int'(x) == (1 << (N-1))) begin
            d.sign = 1'b1;
            d.inf  = 1'b1;
            return d;
        end
        d.sign = x[N-1];
        v = x[N-1] ? (1 << N) - int'(x) : int'(x);
        first = (v >> (N-2)) & 1;
        m = 0;
        for (int i = N-2; i >= 0; i--) begin
            if (((v >> i) & 1) != first) break;
            m++;
        end
        k = (first == 1) ? m - 1 : -m;
        d.regime = (RS+1)'(k);
        rem = N - 2 - m;
        if (rem < 0) rem = 0;
        remval = v & ((1 << rem) - 1);
        if (rem >= int'(ES)) begin
            d.exponent = ES'(remval >> (rem - int'(ES)));
            fb = rem - int'(ES);
        end else begin
            d.exponent = ES'(remval << (int'(ES) - rem));
            fb = 0;
        end
        d.mantissa = N'((1 << (N-1)) + ((remval & ((1 << fb) - 1)) << (N-1-fb)));
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one pair while the sequencer is idle; returns one cycle after acceptance.
    task automatic send_pair(input logic [N-1:0] a, input logic [N-1:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Cycles from acceptance edge to out_valid; -1 if it never arrives.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 12) begin
            step();
            cyc++;
        end
        if (!out_valid) cyc = -1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) step();
        reset     = 1'b0;
        exp_count = 16'd0;
    endtask

    task automatic test_reset();
        in_a = '0;
        in_b = '0;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (pair_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %h want 0000", pair_count); end
        checks++; if (out_a !== decoded_t'(0)) begin errors++; $display("FAIL reset_out_a: got %h want 0", out_a); end
        checks++; if (out_b !== decoded_t'(0)) begin errors++; $display("FAIL reset_out_b: got %h want 0", out_b); end
        reset = 1'b0;
        exp_count = 16'd0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int lat;
        send_pair(8'h40, 8'h00);
        wait_valid(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", lat); end
        checks++; if (out_a !== ref_decode(8'h40)) begin errors++; $display("FAIL basic_out_a: got %h want %h", out_a, ref_decode(8'h40)); end
        checks++; if (out_b !== ref_decode(8'h00)) begin errors++; $display("FAIL basic_out_b: got %h want %h", out_b, ref_decode(8'h00)); end
        checks++; if ({out_a.sign, out_a.regime, out_a.inf, out_a.zero} !== {1'b0, (RS+1)'(0), 1'b0, 1'b0})
            begin errors++; $display("FAIL basic_a_fields: got %h want 0", {out_a.sign, out_a.regime, out_a.inf, out_a.zero}); end
        checks++; if ({out_b.zero, out_b.regime} !== {1'b1, (RS+1)'(0)})
            begin errors++; $display("FAIL basic_b_fields: got %h want zero=1 regime=0", {out_b.zero, out_b.regime}); end
        checks++; if (out_nar !== 1'b0) begin errors++; $display("FAIL basic_nar: got %b want 0", out_nar); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_count++;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b want 0", busy); end
        checks++; if (pair_count !== exp_count) begin errors++; $display("FAIL basic_count: got %h want %h", pair_count, exp_count); end
        checks++; if (out_a !== ref_decode(8'h40)) begin errors++; $display("FAIL basic_retain: got %h want %h", out_a, ref_decode(8'h40)); end
    endtask

    task automatic test_nar();
        int lat;
        send_pair(8'h80, 8'h40);
        wait_valid(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL nar_latency: got %0d want 3", lat); end
        checks++; if ({out_a.inf, out_a.sign} !== 2'b11) begin errors++; $display("FAIL nar_a_flags: got inf,sign=%b want 11", {out_a.inf, out_a.sign}); end
        checks++; if (out_nar !== 1'b1) begin errors++; $display("FAIL nar_flag: got %b want 1", out_nar); end
        checks++; if (out_b !== ref_decode(8'h40)) begin errors++; $display("FAIL nar_out_b: got %h want %h", out_b, ref_decode(8'h40)); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_count++;
        checks++; if (pair_count !== exp_count) begin errors++; $display("FAIL nar_count: got %h want %h", pair_count, exp_count); end
    endtask

    task automatic test_stall();
        int lat;
        logic [N-1:0] a, b;
        a = N'($urandom);
        b = N'($urandom);
        send_pair(a, b);
        // Competing pair offered while decoding and while held must be ignored.
        in_a = ~a;
        in_b = ~b;
        in_valid = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_dec_ready: got %b want 0", in_ready); end
        wait_valid(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL stall_latency: got %0d want 3", lat); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready); end
            checks++; if (out_a !== ref_decode(a)) begin errors++; $display("FAIL stall_a[%0d]: got %h want %h", i, out_a, ref_decode(a)); end
            checks++; if (out_b !== ref_decode(b)) begin errors++; $display("FAIL stall_b[%0d]: got %h want %h", i, out_b, ref_decode(b)); end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_count++;
        checks++; if (pair_count !== exp_count) begin errors++; $display("FAIL stall_count: got %h want %h", pair_count, exp_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] pa [4];
        logic [N-1:0] pb [4];
        int sent, got, cyc, last;
        logic accept;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            pa[i] = N'($urandom);
            pb[i] = N'($urandom);
        end
        sent = 0; got = 0; cyc = 0; last = 0;
        in_a = pa[0];
        in_b = pb[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (got < 4 && cyc < 40) begin
            accept = in_ready && in_valid;
            if (out_valid) begin
                checks++; if ((cyc - last) !== 3) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d want 3", got, cyc - last); end
                checks++; if (out_a !== ref_decode(pa[got])) begin errors++; $display("FAIL b2b_a[%0d]: got %h want %h", got, out_a, ref_decode(pa[got])); end
                checks++; if (out_b !== ref_decode(pb[got])) begin errors++; $display("FAIL b2b_b[%0d]: got %h want %h", got, out_b, ref_decode(pb[got])); end
                last = cyc;
                got++;
                exp_count++;
            end
            step();
            cyc++;
            if (accept) begin
                sent++;
                if (sent < 4) begin
                    in_a = pa[sent];
                    in_b = pb[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        checks++; if (got !== 4) begin errors++; $display("FAIL b2b_pairs: got %0d want 4", got); end
        checks++; if (pair_count !== 16'd4) begin errors++; $display("FAIL b2b_count: got %h want 0004", pair_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [N-1:0] a, b;
        apply_reset();
        send_pair(8'h5A, 8'hA5);
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        checks++; if (pair_count !== exp_count) begin errors++; $display("FAIL mid_count: got %h want %h", pair_count, exp_count); end
        checks++; if (out_a !== decoded_t'(0)) begin errors++; $display("FAIL mid_out_a: got %h want 0", out_a); end
        step();
        reset = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        send_pair(a, b);
        wait_valid(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL mid_latency: got %0d want 3", lat); end
        checks++; if (out_a !== ref_decode(a)) begin errors++; $display("FAIL mid_a: got %h want %h", out_a, ref_decode(a)); end
        checks++; if (out_b !== ref_decode(b)) begin errors++; $display("FAIL mid_b: got %h want %h", out_b, ref_decode(b)); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_count++;
        checks++; if (pair_count !== exp_count) begin errors++; $display("FAIL mid_count_after: got %h want %h", pair_count, exp_count); end
    endtask

    task automatic test_random();
        int lat;
        logic [N-1:0] a, b;
        for (int t = 0; t < 24; t++) begin
            repeat ($urandom_range(0, 2)) step();
            a = N'($urandom);
            b = N'($urandom);
            if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? N'(0) : N'(1 << (N-1));
            if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 0) ? N'(0) : N'(1 << (N-1));
            send_pair(a, b);
            wait_valid(lat);
            repeat ($urandom_range(0, 3)) step();
            checks++; if (lat !== 3) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want 3", t, lat); end
            checks++; if (out_a !== ref_decode(a)) begin errors++; $display("FAIL rnd_a[%0d] in=%h: got %h want %h", t, a, out_a, ref_decode(a)); end
            checks++; if (out_b !== ref_decode(b)) begin errors++; $display("FAIL rnd_b[%0d] in=%h: got %h want %h", t, b, out_b, ref_decode(b)); end
            checks++; if (out_nar !== ((int'(a) == (1 << (N-1))) || (int'(b) == (1 << (N-1)))))
                begin errors++; $display("FAIL rnd_nar[%0d]: got %b a=%h b=%h", t, out_nar, a, b); end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            exp_count++;
            checks++; if (pair_count !== exp_count) begin errors++; $display("FAIL rnd_count[%0d]: got %h want %h", t, pair_count, exp_count); end
        end
    endtask

    task automatic test_wrap();
        int lat;
        force dut.r_pair_count = 16'hFFFF;
        #1;
        release dut.r_pair_count;
        exp_count = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            send_pair(N'($urandom), N'($urandom));
            wait_valid(lat);
            checks++; if (lat !== 3) begin errors++; $display("FAIL wrap_latency[%0d]: got %0d want 3", i, lat); end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            exp_count++;
            checks++; if (pair_count !== exp_count) begin errors++; $display("FAIL wrap_count[%0d]: got %h want %h", i, pair_count, exp_count); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_count = 16'd0;
        test_reset();
        test_basic();
        test_nar();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
